mdu_pipe: RTL

MDU_PIPE -- requirements
Module: mdu_pipe

---
 rtl/mdu_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MSUB support is enabled by defining MDU_MADD_EN.
module mdu_pipe #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MaxCyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
   localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
   localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
   localparam logic [3:0] OpMadd  = 4'd7;
   localparam logic [3:0] OpMsub  = 4'd8;

   typedef enum logic {StIdle, StRun} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [3:0]        op_q, op_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

   logic                      op_legal, accept;
   logic signed [2*WIDTH-1:0] sext_a, sext_b, prod_s;
   logic [2*WIDTH-1:0]        prod_u;
   logic                      a_neg, b_neg;
   logic [WIDTH-1:0]          mag_a, mag_b, quo_u, rem_u, quo, rem;

   always_comb begin
      op_legal = 1'b0;
      case (op)
         OpMult, OpMultu, OpDiv, OpDivu, OpMthi, OpMtlo: op_legal = 1'b1;
`ifdef MDU_MADD_EN
         OpMadd, OpMsub: op_legal = 1'b1;
`endif
         default: op_legal = 1'b0;
      endcase
   end

   assign accept = start && !req && (state_q == StIdle) && op_legal;

   // Division on magnitudes, then sign fix-up: handles MIN / -1 without overflow.
   always_comb begin
      sext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      sext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod_s = sext_a * sext_b;
      prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      a_neg  = (op_q == OpDiv) && a_q[WIDTH-1];
      b_neg  = (op_q == OpDiv) && b_q[WIDTH-1];
      mag_a  = a_neg ? -a_q : a_q;
      mag_b  = b_neg ? -b_q : b_q;
      quo_u  = (mag_b != '0) ? mag_a / mag_b : '0;
      rem_u  = (mag_b != '0) ? mag_a % mag_b : '0;
      quo    = (a_neg ^ b_neg) ? -quo_u : quo_u;
      rem    = a_neg ? -rem_u : rem_u;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (op == OpMthi) begin
                  hi_d = a;
               end else if (op == OpMtlo) begin
                  lo_d = a;
               end else begin
                  op_d    = op;
                  a_d     = a;
                  b_d     = b;
                  cnt_d   = (op == OpDiv || op == OpDivu) ? DivCnt : MultCnt;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (cnt_q == CntW'(1)) begin
               state_d = StIdle;
               cnt_d   = '0;
               case (op_q)
                  OpMult:  {hi_d, lo_d} = prod_s;
                  OpMultu: {hi_d, lo_d} = prod_u;
                  OpDiv, OpDivu: begin
                     if (b_q != '0) begin
                        lo_d = quo;
                        hi_d = rem;
                     end
                  end
`ifdef MDU_MADD_EN
                  OpMadd:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                  OpMsub:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == StRun);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
